// File: rtl/light_pattern_generator.sv
// light_pattern_generator
// Animates an 8-LED bank with one of four patterns (bounce, counter,
// alternate, bar), advancing one step per clock. A rising edge on b selects
// the next pattern. p freezes the display. r is a synchronous active-low reset.
module light_pattern_generator (
  input  logic       r,
  input  logic       b,
  input  logic       p,
  input  logic       Clk,
  output logic [7:0] out
);

  typedef enum logic [1:0] {
    PAT_BOUNCE = 2'd0,
    PAT_COUNT  = 2'd1,
    PAT_ALT    = 2'd2,
    PAT_BAR    = 2'd3
  } pat_e;

  pat_e       pat_q, pat_d;
  logic       dir_q, dir_d;
  logic       b_q;
  logic [7:0] out_q, out_d;

  // Successor of the current display within the current pattern.
  logic [7:0] step_out;
  logic       step_dir;

  // Value shown on the edge that enters a pattern.
  logic [7:0] first_out;

  logic       b_rise;

  assign b_rise = b & ~b_q;
  assign out    = out_q;

  // Pattern successor rules, including recovery from unreachable values.
  always_comb begin
    step_out = out_q;
    step_dir = dir_q;
    unique case (pat_q)
      PAT_BOUNCE: begin
        if (!$onehot(out_q)) begin
          // Anything that is not a single lit LED restarts the bounce.
          step_out = 8'h01;
          step_dir = 1'b0;
        end else if (!dir_q) begin
          if (out_q == 8'h80) begin
            // Already at the left end: turn around rather than fall off.
            step_out = 8'h40;
            step_dir = 1'b1;
          end else begin
            step_out = out_q << 1;
            step_dir = (out_q == 8'h40);
          end
        end else begin
          if (out_q == 8'h01) begin
            // Already at the right end: turn around rather than fall off.
            step_out = 8'h02;
            step_dir = 1'b0;
          end else begin
            step_out = out_q >> 1;
            step_dir = (out_q != 8'h02);
          end
        end
      end
      PAT_COUNT: begin
        step_out = out_q + 8'd1;
        step_dir = dir_q;
      end
      PAT_ALT: begin
        // Only AA steps to 55; everything else (including 55) goes to AA.
        step_out = (out_q == 8'hAA) ? 8'h55 : 8'hAA;
        step_dir = dir_q;
      end
      PAT_BAR: begin
        if (!dir_q) begin
          step_out = {out_q[6:0], 1'b1};
          step_dir = (out_q[6:0] == 7'h7F);
        end else begin
          step_out = {out_q[6:0], 1'b0};
          step_dir = (out_q[6:0] != 7'h00);
        end
      end
      default: begin
        step_out = 8'h01;
        step_dir = 1'b0;
      end
    endcase
  end

  // Next-state selection: button edge beats pause, pause beats stepping.
  always_comb begin
    pat_d     = pat_q;
    dir_d     = dir_q;
    out_d     = out_q;
    first_out = 8'h01;
    if (b_rise) begin
      pat_d = pat_e'(pat_q + 2'd1);
      unique case (pat_d)
        PAT_BOUNCE: first_out = 8'h01;
        PAT_COUNT:  first_out = 8'h00;
        PAT_ALT:    first_out = 8'hAA;
        PAT_BAR:    first_out = 8'h00;
        default:    first_out = 8'h01;
      endcase
      out_d = first_out;
      dir_d = 1'b0;
    end else if (!p) begin
      out_d = step_out;
      dir_d = step_dir;
    end
  end

  // State register; b_q tracks b even in reset so a press held through
  // reset does not advance the pattern afterwards.
  always_ff @(posedge Clk) begin
    b_q <= b;
    if (!r) begin
      pat_q <= PAT_BOUNCE;
      dir_q <= 1'b0;
      out_q <= 8'h01;
    end else begin
      pat_q <= pat_d;
      dir_q <= dir_d;
      out_q <= out_d;
    end
  end

endmodule

// File: tb/tb_light_pattern_generator.sv
// Testbench for light_pattern_generator: constant vector table, a
// hand-written counter-wrap sequence, and randomized stimulus checked
// against a sequence-index reference model.
module tb_light_pattern_generator;

  logic       r, b, p, Clk;
  logic [7:0] out;

  int n_checks = 0;
  int n_fail   = 0;

  light_pattern_generator dut (
    .r   (r),
    .b   (b),
    .p   (p),
    .Clk (Clk),
    .out (out)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  typedef struct {
    logic       r;
    logic       b;
    logic       p;
    logic [7:0] exp;
  } vec_t;

  vec_t vecs[$];

  // Reference model: each pattern is a cyclic list, state is (pattern, index).
  int   m_pat;
  int   m_idx;
  logic m_bq;

  function automatic int pat_len(input int pt);
    case (pt)
      0:       return 14;
      1:       return 256;
      2:       return 2;
      default: return 16;
    endcase
  endfunction

  function automatic logic [7:0] pat_val(input int pt, input int idx);
    logic [8:0] tmp;
    case (pt)
      0: begin
        if (idx < 8) tmp = 9'd1 << idx;
        else         tmp = 9'd1 << (14 - idx);
      end
      1: tmp = 9'(idx);
      2: tmp = (idx == 0) ? 9'h0AA : 9'h055;
      default: begin
        if (idx <= 8) tmp = (9'd1 << idx) - 9'd1;
        else          tmp = (9'h0FF << (idx - 8)) & 9'h0FF;
      end
    endcase
    return tmp[7:0];
  endfunction

  task automatic model_step(input logic rr, input logic bb, input logic pp);
    if (!rr) begin
      m_pat = 0;
      m_idx = 0;
    end else if (bb && !m_bq) begin
      m_pat = (m_pat + 1) % 4;
      m_idx = 0;
    end else if (!pp) begin
      m_idx = (m_idx + 1) % pat_len(m_pat);
    end
    m_bq = bb;
  endtask

  task automatic check(input string name, input int n, input logic [7:0] got,
                       input logic [7:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s #%0d: out=%02h expected %02h", name, n, got, exp);
    end else begin
      $display("ok   %s #%0d: out=%02h", name, n, got);
    end
  endtask

  // Drive inputs away from the active edge, then sample just after it.
  task automatic apply(input logic rr, input logic bb, input logic pp);
    @(negedge Clk);
    r = rr;
    b = bb;
    p = pp;
    @(posedge Clk);
    #1;
  endtask

  function automatic void add(input logic rr, input logic bb, input logic pp,
                              input logic [7:0] e);
    vec_t v;
    v.r = rr; v.b = bb; v.p = pp; v.exp = e;
    vecs.push_back(v);
  endfunction

  initial begin
    logic [7:0] bounce_seq [16];
    logic [7:0] bar_seq [15];
    logic [7:0] cnt;
    logic       rr, bb, pp;

    r = 1'b0; b = 1'b0; p = 1'b0;

    bounce_seq = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h40,
                   8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01, 8'h02, 8'h04};
    bar_seq    = '{8'h07, 8'h0F, 8'h1F, 8'h3F, 8'h7F, 8'hFF, 8'hFE, 8'hFC,
                   8'hF8, 8'hF0, 8'hE0, 8'hC0, 8'h80, 8'h00, 8'h01};

    // Reset, then a full bounce period.
    add(0, 0, 0, 8'h01);
    for (int i = 0; i < 15; i++) add(1, 0, 0, bounce_seq[i]);
    // Walk to 08, pause for 4 edges, release.
    add(1, 0, 0, 8'h04);
    add(1, 0, 0, 8'h08);
    for (int i = 0; i < 4; i++) add(1, 0, 1, 8'h08);
    add(1, 0, 0, 8'h10);
    add(1, 0, 0, 8'h20);
    // Cycle through all patterns with 2-cycle pulses.
    add(1, 1, 0, 8'h00); add(1, 1, 0, 8'h01); add(1, 0, 0, 8'h02);
    add(1, 1, 0, 8'hAA); add(1, 1, 0, 8'h55); add(1, 0, 0, 8'hAA);
    add(1, 1, 0, 8'h00); add(1, 1, 0, 8'h01); add(1, 0, 0, 8'h03);
    for (int i = 0; i < 15; i++) add(1, 0, 0, bar_seq[i]);
    add(1, 1, 0, 8'h01); add(1, 0, 0, 8'h02);
    // Held button: one advance only, pattern keeps stepping.
    add(1, 1, 0, 8'h00);
    for (int i = 1; i < 10; i++) add(1, 1, 0, 8'(i));
    add(1, 0, 0, 8'h0A);
    // Button edge overrides pause.
    add(1, 1, 1, 8'hAA);
    add(1, 1, 1, 8'hAA);
    add(1, 0, 0, 8'h55);
    // Reset overrides button and pause; the edge is absorbed.
    add(0, 1, 1, 8'h01);
    add(0, 1, 1, 8'h01);
    add(1, 0, 0, 8'h02);
    add(1, 0, 0, 8'h04);
    add(0, 1, 0, 8'h01);
    add(1, 1, 0, 8'h02);
    add(1, 0, 0, 8'h04);

    foreach (vecs[i]) begin
      apply(vecs[i].r, vecs[i].b, vecs[i].p);
      check("vec", i, out, vecs[i].exp);
    end

    // Counter wrap: enter pattern 1 and count a full 256 steps.
    apply(1, 1, 0);
    check("cnt_enter", 0, out, 8'h00);
    cnt = 8'h00;
    for (int i = 1; i <= 256; i++) begin
      apply(1, 0, 0);
      cnt = cnt + 8'd1;
      if (i == 255 || i == 256) check("cnt_wrap", i, out, cnt);
    end
    check("cnt_final", 0, out, 8'h00);

    // Randomized run against the sequence-index model.
    apply(0, 0, 0);
    m_pat = 0; m_idx = 0; m_bq = 1'b0;
    check("rnd_reset", 0, out, pat_val(m_pat, m_idx));
    bb = 1'b0;
    for (int i = 0; i < 1500; i++) begin
      rr = ($urandom_range(0, 49) != 0);
      if ($urandom_range(0, 5) == 0) bb = ~bb;
      pp = ($urandom_range(0, 4) == 0);
      apply(rr, bb, pp);
      model_step(rr, bb, pp);
      check("rnd", i, out, pat_val(m_pat, m_idx));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
